// File: rtl/servo_pkg.sv
// Shared servo types and default constants (also used by the PID controller).
package servo_pkg;

  typedef logic [17:0] duty_t;
  typedef logic [19:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pwm_state_e;

  // 20 ms frame at 50 MHz; 1.0 / 1.5 / 2.0 ms pulse widths
  localparam int DEF_PERIOD_CYC  = 1_000_000;
  localparam int DEF_MIN_DUTY    = 50_000;
  localparam int DEF_MAX_DUTY    = 100_000;
  localparam int DEF_CENTER_DUTY = 75_000;
  localparam int DEF_SLEW_STEP   = 1_000;

  // Duty words are compared against the 20-bit frame counter unsigned
  function automatic cnt_t ext_duty(input duty_t d);
    return {2'b00, d};
  endfunction

endpackage

// File: rtl/servo_duty_shaper.sv
// Combinational duty shaping: zero means "hold", otherwise clamp to the
// servo-safe window. With PWM_SLEW_LIMIT_EN defined the result moves toward
// the clamped target by at most SLEW_STEP per frame.
module servo_duty_shaper
  import servo_pkg::*;
#(
  parameter int MIN_DUTY  = DEF_MIN_DUTY,
  parameter int MAX_DUTY  = DEF_MAX_DUTY,
  parameter int SLEW_STEP = DEF_SLEW_STEP
) (
  input  logic [17:0] duty_in,
  input  logic [17:0] duty_cur,
  output logic [17:0] duty_next
);

`ifdef PWM_SLEW_LIMIT_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  localparam duty_t LO_D = duty_t'(MIN_DUTY);
  localparam duty_t HI_D = duty_t'(MAX_DUTY);
  localparam cnt_t  LO   = cnt_t'(MIN_DUTY);
  localparam cnt_t  HI   = cnt_t'(MAX_DUTY);
  localparam cnt_t  STEP = cnt_t'(SLEW_STEP);

  cnt_t  req;
  cnt_t  cur;
  cnt_t  target;
  cnt_t  delta;
  cnt_t  slewed;
  cnt_t  moved;
  duty_t duty_fit;

  // Clamp, optional slew toward target, then a final saturation so the
  // result stays inside the window even if the held value started outside it.
  always_comb begin
    req      = ext_duty(duty_in);
    cur      = ext_duty(duty_cur);
    target   = req;
    delta    = '0;
    slewed   = cur;
    moved    = cur;
    duty_fit = duty_cur;

    if (req < LO) begin
      target = LO;
    end else if (req > HI) begin
      target = HI;
    end

    // slewed always lies between cur and target, so no overflow is possible
    if (target >= cur) begin
      delta  = target - cur;
      slewed = cur + ((delta > STEP) ? STEP : delta);
    end else begin
      delta  = cur - target;
      slewed = cur - ((delta > STEP) ? STEP : delta);
    end

    moved = SLEW_EN ? slewed : target;

    if (moved > HI) begin
      duty_fit = HI_D;
    end else if (moved < LO) begin
      duty_fit = LO_D;
    end else begin
      duty_fit = moved[17:0];
    end

    duty_next = (duty_in == '0) ? duty_cur : duty_fit;
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: fixed-length frames, pulse width taken from duty_in
// only at frame boundaries, clamped (and optionally slew limited).
// Optional feature macro: PWM_SLEW_LIMIT_EN (see servo_duty_shaper).
//
// Timing: every output is a flop computed from the *next* state/counter, so
// the duty loaded for a frame is already in force during frame cycle 0 and
// pwm_out / period_start line up with the counter without a one-cycle skew.
// The duty word is sampled on the cycle that hands over to frame cycle 0
// (the enabling cycle in IDLE, or the last cycle of the previous frame).
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
  parameter int MIN_DUTY    = DEF_MIN_DUTY,
  parameter int MAX_DUTY    = DEF_MAX_DUTY,
  parameter int CENTER_DUTY = DEF_CENTER_DUTY,
  parameter int SLEW_STEP   = DEF_SLEW_STEP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [17:0] duty_in,
  output logic        pwm_out,
  output logic        period_start,
  output logic [17:0] duty_active,
  output logic        busy
);

  localparam cnt_t  LAST_CNT   = cnt_t'(PERIOD_CYC - 1);
  localparam duty_t CENTER_D   = duty_t'(CENTER_DUTY);

  pwm_state_e state_reg;
  pwm_state_e state_next;
  cnt_t       cnt_reg;
  cnt_t       cnt_next;
  duty_t      duty_active_reg;
  duty_t      duty_shaped;
  duty_t      duty_sel;
  logic       pwm_out_reg;
  logic       pwm_next;
  logic       period_start_reg;
  logic       busy_reg;
  logic       busy_next;
  logic       load_frame;
  logic       frame_last;

  servo_duty_shaper #(
    .MIN_DUTY  (MIN_DUTY),
    .MAX_DUTY  (MAX_DUTY),
    .SLEW_STEP (SLEW_STEP)
  ) u_shaper (
    .duty_in   (duty_in),
    .duty_cur  (duty_active_reg),
    .duty_next (duty_shaped)
  );

  assign frame_last = (cnt_reg == LAST_CNT);

  // Next-state and frame counter: a started frame always runs to its end;
  // enable is only consulted for leaving/continuing at the frame boundary.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load_frame = 1'b0;
    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (enable) begin
          state_next = RUN;
          load_frame = 1'b1;
        end
      end
      RUN: begin
        if (frame_last) begin
          cnt_next = '0;
          if (enable) begin
            load_frame = 1'b1;
          end else begin
            // enable dropped on the very last cycle: frame is already complete
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + cnt_t'(1);
          if (!enable) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (frame_last) begin
          cnt_next = '0;
          if (enable) begin
            state_next = RUN;
            load_frame = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + cnt_t'(1);
          if (enable) begin
            state_next = RUN;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output look-ahead: compare the upcoming counter value against the duty
  // that will be in force for it; duty >= PERIOD_CYC simply holds high.
  always_comb begin
    duty_sel  = load_frame ? duty_shaped : duty_active_reg;
    busy_next = (state_next != IDLE);
    pwm_next  = busy_next && (cnt_next < ext_duty(duty_sel));
  end

  // FSM state, counter, duty register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      duty_active_reg  <= CENTER_D;
      pwm_out_reg      <= 1'b0;
      period_start_reg <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      pwm_out_reg      <= pwm_next;
      period_start_reg <= load_frame;
      busy_reg         <= busy_next;
      if (load_frame) begin
        duty_active_reg <= duty_shaped;
      end
    end
  end

  assign pwm_out      = pwm_out_reg;
  assign period_start = period_start_reg;
  assign duty_active  = duty_active_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen (PERIOD=100, MIN=20, MAX=60,
// CENTER=40, SLEW=5). Expected duty per frame is pushed to a queue when the
// duty/enable stimulus is driven and popped when the frame appears.
module tb_servo_pwm_gen;

  localparam int PERIOD = 100;
  localparam int MIN_D  = 20;
  localparam int MAX_D  = 60;
  localparam int CTR_D  = 40;
  localparam int SLEW   = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [17:0] duty_in;
  logic        pwm_out;
  logic        period_start;
  logic [17:0] duty_active;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int model;

  servo_pwm_gen #(
    .PERIOD_CYC  (PERIOD),
    .MIN_DUTY    (MIN_D),
    .MAX_DUTY    (MAX_D),
    .CENTER_DUTY (CTR_D),
    .SLEW_STEP   (SLEW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .duty_in      (duty_in),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty_active  (duty_active),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Reference shaping: hold on zero, clamp, optional slew
  function automatic int model_shape(input int req, input int cur);
    int tgt;
    if (req == 0) return cur;
    tgt = (req < MIN_D) ? MIN_D : ((req > MAX_D) ? MAX_D : req);
`ifdef PWM_SLEW_LIMIT_EN
    if (tgt > cur + SLEW) return cur + SLEW;
    if (tgt < cur - SLEW) return cur - SLEW;
`endif
    return tgt;
  endfunction

  // Wait for a frame start, then observe the full frame; up to two actions
  // (kind 1 = set duty_in, kind 2 = set enable) are applied after sampling
  // the given frame cycle.
  task automatic measure_frame(input int a_cyc, input int a_kind, input int a_val,
                               input int b_cyc, input int b_kind, input int b_val,
                               output int waited, output int width, output int oddities,
                               output int da, output bit tmo);
    bit seen_low;
    waited = 0; width = 0; oddities = 0; da = 0; tmo = 1'b0; seen_low = 1'b0;
    do begin
      @(negedge clk);
      waited++;
    end while (period_start !== 1'b1 && waited < 400);
    if (period_start !== 1'b1) begin
      tmo = 1'b1;
      return;
    end
    da = int'(duty_active);
    for (int k = 0; k < PERIOD; k++) begin
      if (k > 0) @(negedge clk);
      if (pwm_out === 1'b1) begin
        width++;
        if (seen_low) oddities++;
      end else begin
        seen_low = 1'b1;
      end
      if (k > 0 && period_start !== 1'b0) oddities++;
      if (busy !== 1'b1) oddities++;
      if (int'(duty_active) != da) oddities++;
      if (k == a_cyc && a_kind == 1) duty_in = 18'(a_val);
      if (k == a_cyc && a_kind == 2) enable = a_val[0];
      if (k == b_cyc && b_kind == 1) duty_in = 18'(b_val);
      if (k == b_cyc && b_kind == 2) enable = b_val[0];
    end
  endtask

  task automatic test_reset();
    int idle_bad;
    rst_n = 1'b0; enable = 1'b0; duty_in = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
    n_cmp++; if (period_start !== 1'b0) begin n_bad++; $display("FAIL reset_ps: got %b want 0", period_start); end
    n_cmp++; if (duty_active !== 18'(CTR_D)) begin n_bad++; $display("FAIL reset_duty: got %0d want %0d", duty_active, CTR_D); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    idle_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (pwm_out !== 1'b0 || busy !== 1'b0 || period_start !== 1'b0) idle_bad++;
    end
    n_cmp++; if (idle_bad != 0) begin n_bad++; $display("FAIL reset_idle: %0d active cycles, want 0", idle_bad); end
    model = CTR_D;
    $display("reset: done, duty_active=%0d", duty_active);
  endtask

  task automatic test_hold_center();
    int w, wd, odd, da, exp;
    bit tmo;
    duty_in = '0; enable = 1'b1;
    exp_q.push_back(model_shape(0, model));
    for (int i = 0; i < 2; i++) begin
      exp = exp_q.pop_front();
      measure_frame(-1, 0, 0, -1, 0, 0, wd, w, odd, da, tmo);
      n_cmp++;
      if (tmo) begin n_bad++; $display("FAIL hold_timeout[%0d]: no period_start in 400 cycles", i); continue; end
      if (da != exp) begin n_bad++; $display("FAIL hold_duty[%0d]: got %0d want %0d", i, da, exp); end
      n_cmp++; if (w != exp) begin n_bad++; $display("FAIL hold_width[%0d]: got %0d want %0d", i, w, exp); end
      n_cmp++; if (odd != 0 || wd != 1) begin n_bad++; $display("FAIL hold_shape[%0d]: oddities %0d gap %0d, want 0 and 1", i, odd, wd); end
      model = exp;
      exp_q.push_back(model_shape(int'(duty_in), model));
      $display("hold frame %0d: duty=%0d width=%0d", i, da, w);
    end
  endtask

  task automatic test_shaping();
    int acyc[7] = '{50, 50, 50, 50, 50, 10, -1};
    int aval[7] = '{30, 200, 5, 0, 30, 50, 0};
    int w, wd, odd, da, exp;
    bit tmo;
    for (int i = 0; i < 7; i++) begin
      exp = exp_q.pop_front();
      measure_frame(acyc[i], (acyc[i] >= 0) ? 1 : 0, aval[i], -1, 0, 0, wd, w, odd, da, tmo);
      n_cmp++;
      if (tmo) begin n_bad++; $display("FAIL shape_timeout[%0d]: no period_start in 400 cycles", i); continue; end
      if (da != exp) begin n_bad++; $display("FAIL shape_duty[%0d]: got %0d want %0d", i, da, exp); end
      n_cmp++; if (w != exp) begin n_bad++; $display("FAIL shape_width[%0d]: got %0d want %0d", i, w, exp); end
      n_cmp++; if (odd != 0 || wd != 1) begin n_bad++; $display("FAIL shape_glitch[%0d]: oddities %0d gap %0d, want 0 and 1", i, odd, wd); end
      model = exp;
      exp_q.push_back(model_shape(int'(duty_in), model));
      $display("shape frame %0d: duty_in->%0d duty=%0d width=%0d", i, duty_in, da, w);
    end
  endtask

  task automatic test_drain();
    int w, wd, odd, da, exp, idle_bad;
    bit tmo;
    // enable drops at cycle 15: frame must still run to cycle 99
    exp = exp_q.pop_front();
    measure_frame(15, 2, 0, -1, 0, 0, wd, w, odd, da, tmo);
    n_cmp++;
    if (tmo) begin n_bad++; $display("FAIL drain_timeout: no period_start in 400 cycles"); end
    else begin
      if (w != exp || da != exp) begin n_bad++; $display("FAIL drain_frame: width %0d duty %0d want %0d", w, da, exp); end
      n_cmp++; if (odd != 0) begin n_bad++; $display("FAIL drain_complete: oddities %0d want 0", odd); end
    end
    exp_q.delete();
    model = exp;
    idle_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (pwm_out !== 1'b0 || busy !== 1'b0 || period_start !== 1'b0) idle_bad++;
    end
    n_cmp++; if (idle_bad != 0) begin n_bad++; $display("FAIL drain_idle: %0d active cycles want 0", idle_bad); end
    $display("drain: frame width=%0d then idle", w);
    // re-enable; then drop at 20 and restore at 60 (DRAIN -> RUN, no gap)
    enable = 1'b1;
    exp_q.push_back(model_shape(int'(duty_in), model));
    for (int i = 0; i < 2; i++) begin
      exp = exp_q.pop_front();
      if (i == 0) measure_frame(20, 2, 0, 60, 2, 1, wd, w, odd, da, tmo);
      else        measure_frame(-1, 0, 0, -1, 0, 0, wd, w, odd, da, tmo);
      n_cmp++;
      if (tmo) begin n_bad++; $display("FAIL redrain_timeout[%0d]: no period_start in 400 cycles", i); continue; end
      if (da != exp || w != exp) begin n_bad++; $display("FAIL redrain_frame[%0d]: duty %0d width %0d want %0d", i, da, w, exp); end
      n_cmp++; if (odd != 0 || wd != 1) begin n_bad++; $display("FAIL redrain_gap[%0d]: oddities %0d gap %0d want 0 and 1", i, odd, wd); end
      model = exp;
      exp_q.push_back(model_shape(int'(duty_in), model));
      $display("redrain frame %0d: duty=%0d width=%0d wait=%0d", i, da, w, wd);
    end
  endtask

  task automatic test_reset_midframe();
    int w, wd, odd, da, exp, waited;
    bit tmo;
    void'(exp_q.pop_front());
    waited = 0;
    do begin @(negedge clk); waited++; end while (period_start !== 1'b1 && waited < 400);
    n_cmp++;
    if (period_start !== 1'b1) begin n_bad++; $display("FAIL rstmid_timeout: no period_start in 400 cycles"); end
    repeat (10) @(negedge clk);
    n_cmp++; if (pwm_out !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: pwm_out %b want 1 at cycle 10", pwm_out); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL rstmid_pwm: got %b want 0 immediately", pwm_out); end
    n_cmp++; if (busy !== 1'b0 || period_start !== 1'b0) begin n_bad++; $display("FAIL rstmid_flags: busy %b ps %b want 0 0", busy, period_start); end
    exp_q.delete();
    duty_in = '0;
    model = CTR_D;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (duty_active !== 18'(CTR_D)) begin n_bad++; $display("FAIL rstmid_duty: got %0d want %0d", duty_active, CTR_D); end
    exp_q.push_back(model_shape(0, model));
    exp = exp_q.pop_front();
    measure_frame(50, 1, 60, -1, 0, 0, wd, w, odd, da, tmo);
    n_cmp++;
    if (tmo) begin n_bad++; $display("FAIL rstmid_restart: no period_start in 400 cycles"); end
    else if (da != exp || w != exp || odd != 0) begin n_bad++; $display("FAIL rstmid_restart: duty %0d width %0d odd %0d want %0d", da, w, odd, exp); end
    model = exp;
    exp_q.push_back(model_shape(int'(duty_in), model));
    $display("reset midframe: restart duty=%0d width=%0d", da, w);
  endtask

  task automatic test_slew();
    int w, wd, odd, da, exp;
    bit tmo;
    for (int i = 0; i < 4; i++) begin
      exp = exp_q.pop_front();
      measure_frame(-1, 0, 0, -1, 0, 0, wd, w, odd, da, tmo);
      n_cmp++;
      if (tmo) begin n_bad++; $display("FAIL slew_timeout[%0d]: no period_start in 400 cycles", i); continue; end
      if (da != exp) begin n_bad++; $display("FAIL slew_duty[%0d]: got %0d want %0d", i, da, exp); end
      n_cmp++; if (w != exp || odd != 0 || wd != 1) begin n_bad++; $display("FAIL slew_frame[%0d]: width %0d odd %0d gap %0d want %0d 0 1", i, w, odd, wd, exp); end
      model = exp;
      exp_q.push_back(model_shape(int'(duty_in), model));
      $display("slew frame %0d: duty=%0d width=%0d", i, da, w);
    end
  endtask

  initial begin
    test_reset();
    test_hold_center();
    test_shaping();
    test_drain();
    test_reset_midframe();
    test_slew();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
